div_ratio_ctrl: RTL and testbench



---
 rtl/div_ratio_ctrl_if.sv | 35 +++
 rtl/div_ratio_ctrl.sv | 93 +++++++++
 tb/tb_div_ratio_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/div_ratio_ctrl_if.sv
// Configuration handshake and divider-control bundle between a config source and div_ratio_ctrl.
interface div_ratio_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             i_cfg_valid;
  logic [WIDTH-1:0] i_cfg_ratio;
  logic             i_cfg_en;
  logic             o_cfg_ready;
  logic [WIDTH-1:0] o_div_ratio;
  logic             o_clk_en;
  logic             o_busy;
  logic             o_cfg_err;

  modport master (
    output i_cfg_valid,
    output i_cfg_ratio,
    output i_cfg_en,
    input  o_cfg_ready,
    input  o_div_ratio,
    input  o_clk_en,
    input  o_busy,
    input  o_cfg_err
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_ratio,
    input  i_cfg_en,
    output o_cfg_ready,
    output o_div_ratio,
    output o_clk_en,
    output o_busy,
    output o_cfg_err
  );
endinterface

// File: rtl/div_ratio_ctrl.sv
// Sequences divide-ratio changes so the downstream clock divider is disabled
// for a quiet period before its ratio input moves, then re-enabled.
module div_ratio_ctrl #(
  parameter int WIDTH        = 4,
  parameter int QUIET_CYCLES = 2,
  parameter int RESET_RATIO  = 8
) (
  input  logic            i_ref_clk,
  input  logic            i_rst,
  div_ratio_ctrl_if.slave cfg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUIESCE = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_RESUME  = 2'd3;

  localparam logic [WIDTH-1:0] RESET_VAL  = WIDTH'(RESET_RATIO);
  localparam logic [3:0]       QUIET_LOAD = 4'(QUIET_CYCLES - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shadow_ratio;
  logic             shadow_en;
  logic [3:0]       quiet_cnt;
  logic             accept;
  logic             is_zero;
  logic             is_same;

  assign accept  = cfg.i_cfg_valid && cfg.o_cfg_ready;
  assign is_zero = (cfg.i_cfg_ratio == '0);
  assign is_same = (cfg.i_cfg_ratio == cfg.o_div_ratio) && (cfg.i_cfg_en == cfg.o_clk_en);

  // Enable-off requests bypass the quiet period: the divider is being stopped
  // anyway, so ratio and enable can move together without a glitch.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state           <= S_IDLE;
      shadow_ratio    <= '0;
      shadow_en       <= 1'b0;
      quiet_cnt       <= '0;
      cfg.o_div_ratio <= RESET_VAL;
      cfg.o_clk_en    <= 1'b0;
      cfg.o_cfg_ready <= 1'b1;
      cfg.o_busy      <= 1'b0;
      cfg.o_cfg_err   <= 1'b0;
    end else begin
      cfg.o_cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_zero) begin
              cfg.o_cfg_err <= 1'b1;
            end else if (is_same) begin
              state <= S_IDLE;
            end else if (!cfg.i_cfg_en) begin
              cfg.o_clk_en    <= 1'b0;
              cfg.o_div_ratio <= cfg.i_cfg_ratio;
            end else begin
              shadow_ratio    <= cfg.i_cfg_ratio;
              shadow_en       <= cfg.i_cfg_en;
              quiet_cnt       <= QUIET_LOAD;
              cfg.o_clk_en    <= 1'b0;
              cfg.o_busy      <= 1'b1;
              cfg.o_cfg_ready <= 1'b0;
              state           <= S_QUIESCE;
            end
          end
        end
        S_QUIESCE: begin
          if (quiet_cnt == '0) begin
            cfg.o_div_ratio <= shadow_ratio;
            state           <= S_LOAD;
          end else begin
            quiet_cnt <= quiet_cnt - 4'd1;
          end
        end
        S_LOAD: begin
          state <= S_RESUME;
        end
        S_RESUME: begin
          cfg.o_clk_en    <= shadow_en;
          cfg.o_busy      <= 1'b0;
          cfg.o_cfg_ready <= 1'b1;
          state           <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed and randomized bench for div_ratio_ctrl, checked against a
// timeline-based reference model of ratio changes.
module tb_div_ratio_ctrl;

  localparam int WIDTH = 4;
  localparam int QUIET = 2;
  localparam int RRAT  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  div_ratio_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_ratio_ctrl #(
    .WIDTH(WIDTH),
    .QUIET_CYCLES(QUIET),
    .RESET_RATIO(RRAT)
  ) dut (
    .i_ref_clk(clk),
    .i_rst(rst),
    .cfg(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: a change started at edge t0 loads the ratio at t0+QUIET and
  // finishes (enable restored, ready again) at t0+QUIET+2.
  int   cyc = 0;
  int   busy_until = 0;
  int   load_at = -1;
  int   m_ratio = RRAT;
  logic m_en = 1'b0;
  logic m_err = 1'b0;
  logic m_busy = 1'b0;
  logic m_ready = 1'b1;
  int   pend_ratio = 0;
  logic pend_en = 1'b0;

  task automatic model_edge(input logic r, input logic v, input int ratio, input logic en);
    cyc++;
    m_err = 1'b0;
    if (r) begin
      m_ratio    = RRAT;
      m_en       = 1'b0;
      busy_until = cyc;
      load_at    = -1;
    end else if (cyc <= busy_until) begin
      if (cyc == load_at) m_ratio = pend_ratio;
      if (cyc == busy_until) m_en = pend_en;
    end else if (v) begin
      if (ratio == 0) begin
        m_err = 1'b1;
      end else if (ratio == m_ratio && en == m_en) begin
        m_err = 1'b0;
      end else if (!en) begin
        m_ratio = ratio;
        m_en    = 1'b0;
      end else begin
        pend_ratio = ratio;
        pend_en    = en;
        m_en       = 1'b0;
        load_at    = cyc + QUIET;
        busy_until = cyc + QUIET + 2;
      end
    end
    m_busy  = (cyc < busy_until);
    m_ready = !m_busy;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s at edge %0d: observed %0d expected %0d", tag, cyc, observed, expected);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic applyStimulus(input logic r, input logic v, input int ratio, input logic en);
    rst             = r;
    bus.i_cfg_valid = v;
    bus.i_cfg_ratio = WIDTH'(ratio);
    bus.i_cfg_en    = en;
    @(posedge clk);
    model_edge(r, v, ratio, en);
    #1;
    checkOutput("div_ratio", 8'(bus.o_div_ratio), 8'(m_ratio));
    checkOutput("clk_en",    8'(bus.o_clk_en),    8'(m_en));
    checkOutput("cfg_ready", 8'(bus.o_cfg_ready), 8'(m_ready));
    checkOutput("busy",      8'(bus.o_busy),      8'(m_busy));
    checkOutput("cfg_err",   8'(bus.o_cfg_err),   8'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int r_ratio;
    $display("[TB] start");
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_ratio = '0;
    bus.i_cfg_en    = 1'b0;
    #2;

    // reset with a concurrent offer that must be discarded
    applyStimulus(1'b1, 1'b1, 3, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);

    // 8 -> 4 with enable
    applyStimulus(1'b0, 1'b1, 4, 1'b1);
    idle(5);

    // zero ratio rejected
    applyStimulus(1'b0, 1'b1, 0, 1'b1);
    idle(2);

    // identical config is a no-op
    applyStimulus(1'b0, 1'b1, 4, 1'b1);
    idle(2);

    // 6 then held 3 during busy
    applyStimulus(1'b0, 1'b1, 6, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 3, 1'b1);
    idle(6);

    // reset one cycle after accepting ratio 2
    applyStimulus(1'b0, 1'b1, 2, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    idle(5);

    // ratio 1 bypass, then 4/en, then 5 with enable off
    applyStimulus(1'b0, 1'b1, 1, 1'b1);
    idle(5);
    applyStimulus(1'b0, 1'b1, 4, 1'b1);
    idle(5);
    applyStimulus(1'b0, 1'b1, 5, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_ratio = ($urandom_range(0, 5) == 0) ? m_ratio : int'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), r_ratio,
                    1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
